// File: rtl/debug_dump_tx.sv
`default_nettype none
// ============================================================================
// Module      : debug_dump_tx
// Description : Captures the DataPath debug outputs on a processor halt or a
//               manual request. It then sends the snapshot as one framed byte
//               stream over a valid/ready interface: header byte, 184 payload
//               bytes (LSB first), and an optional XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_dump_tx #(
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter bit         SEND_CSUM   = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1023:0] du_reg,
    input  logic [255:0]  du_mem,
    input  logic [63:0]   du_if_id,
    input  logic [125:0]  du_id_ex,
    input  logic          du_halt,
    input  logic          dump_req,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done
);

    localparam int         SHADOW_W = 1472;
    localparam logic [7:0] LAST_IDX = 8'd183;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_LAST    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  halt_q;
    logic [SHADOW_W-1:0]   shadow_q, shadow_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            csum_q, csum_d;
    logic                  w_trigger;

    // A halt rising edge or a manual request starts a frame, but only from IDLE.
    // Requests that arrive at any other time are dropped, not queued.
    assign w_trigger = (state_q == ST_IDLE) && ((du_halt && !halt_q) || dump_req);

    // Next-state, snapshot/checksum update and Moore output decode
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_trigger) begin
                    state_d  = ST_HDR;
                    shadow_d = {2'b00, du_id_ex, du_if_id, du_mem, du_reg};
                    cnt_d    = 8'd0;
                    csum_d   = 8'h00;
                end
            end
            ST_HDR: begin
                tx_data  = HEADER_BYTE;
                tx_valid = 1'b1;
                busy     = 1'b1;
                if (tx_ready) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                tx_data  = shadow_q[7:0];
                tx_valid = 1'b1;
                busy     = 1'b1;
                if (tx_ready) begin
                    shadow_d = {8'h00, shadow_q[SHADOW_W-1:8]};
                    csum_d   = csum_q ^ shadow_q[7:0];
                    if (cnt_q == LAST_IDX) begin
                        // The counter stays at LAST_IDX. It is reloaded at the next trigger.
                        if (SEND_CSUM) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_LAST;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_CSUM: begin
                tx_data  = csum_q;
                tx_valid = 1'b1;
                busy     = 1'b1;
                if (tx_ready) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, snapshot, counter and checksum registers. halt_q samples every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            halt_q   <= 1'b0;
            shadow_q <= '0;
            cnt_q    <= 8'd0;
            csum_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            halt_q   <= du_halt;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
        end
    end

endmodule
`default_nettype wire
